// File: rtl/accum_pkg.sv
// Shared types and default widths for the product accumulator.
package accum_pkg;

    localparam int unsigned PW_DEFAULT = 8;
    localparam int unsigned LW_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/product_accumulator_props.sv
// Handshake properties for product_accumulator, attached with bind.
module product_accumulator_props #(
    parameter int unsigned PW = 8,
    parameter int unsigned LW = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             p_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [PW+LW-1:0] out_sum,
    input logic [LW:0]      out_count
);

    a_valid_held: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> out_valid);

    a_result_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_sum) && $stable(out_count)));

    a_ready_excl: assert property (@(posedge clk) disable iff (rst)
        !(p_ready && out_valid));

endmodule

bind product_accumulator product_accumulator_props #(
    .PW(PW),
    .LW(LW)
) u_props (
    .clk       (clk),
    .rst       (rst),
    .p_ready   (p_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
);

// File: rtl/product_accumulator.sv
// Sums a frame of len products from an upstream multiplier and presents the
// total and product count with a valid/ready handshake.
module product_accumulator
    import accum_pkg::*;
#(
    parameter int unsigned PW = PW_DEFAULT,
    parameter int unsigned LW = LW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PW-1:0]    p_in,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [LW-1:0]    len,
    output logic [PW+LW-1:0] out_sum,
    output logic [LW:0]      out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned SW = PW + LW;
    localparam int unsigned CW = LW + 1;
    localparam logic [CW-1:0] FULL_FRAME = CW'(2 ** LW);

    state_t          state;
    state_t          state_next;
    logic [SW-1:0]   acc;
    logic [SW-1:0]   acc_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [CW-1:0]   target;
    logic [CW-1:0]   target_next;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   frame_len;
    logic            xfer;

    // Handshake flags decode directly from the state register.
    assign p_ready   = (state != DONE);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_count = cnt;

    assign xfer      = p_valid && p_ready;
    assign cnt_inc   = cnt + CW'(1);
    assign frame_len = (len == '0) ? FULL_FRAME : CW'(len);

    // Next-state and datapath update.
    always_comb begin
        state_next  = state;
        acc_next    = acc;
        cnt_next    = cnt;
        target_next = target;
        case (state)
            IDLE: begin
                if (xfer) begin
                    acc_next    = SW'(p_in);
                    cnt_next    = CW'(1);
                    target_next = frame_len;
                    state_next  = (frame_len == CW'(1)) ? DONE : ACC;
                end
            end
            ACC: begin
                if (xfer) begin
                    acc_next   = acc + SW'(p_in);
                    cnt_next   = cnt_inc;
                    state_next = (cnt_inc == target) ? DONE : ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset discards any partial or unconsumed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            target <= '0;
        end else begin
            state  <= state_next;
            acc    <= acc_next;
            cnt    <= cnt_next;
            target <= target_next;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed, table-driven bench for product_accumulator (PW=8, LW=4).
module tb_product_accumulator;

    localparam int unsigned PW = 8;
    localparam int unsigned LW = 4;

    typedef struct {
        logic            rst;
        logic            pv;
        logic [PW-1:0]   pin;
        logic [LW-1:0]   len;
        logic            ordy;
        logic            e_rdy;
        logic            e_vld;
        logic [PW+LW-1:0] e_sum;
        logic [LW:0]     e_cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [PW-1:0]    p_in;
    logic             p_valid;
    logic             p_ready;
    logic [LW-1:0]    len;
    logic [PW+LW-1:0] out_sum;
    logic [LW:0]      out_count;
    logic             out_valid;
    logic             out_ready;

    int vectors = 0;
    int miscompares = 0;
    vec_t vecs[$];

    product_accumulator #(.PW(PW), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_in      (p_in),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .len       (len),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic pv, input int pin, input int ln,
                       input logic ordy, input logic e_rdy, input logic e_vld,
                       input int e_sum, input int e_cnt);
        vec_t v;
        v.rst   = r;
        v.pv    = pv;
        v.pin   = PW'(pin);
        v.len   = LW'(ln);
        v.ordy  = ordy;
        v.e_rdy = e_rdy;
        v.e_vld = e_vld;
        v.e_sum = (PW+LW)'(e_sum);
        v.e_cnt = (LW+1)'(e_cnt);
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; p_valid = 1'b0; p_in = '0; len = '0; out_ready = 1'b0;

        //  rst pv pin len ordy | rdy vld sum cnt   (outputs after the edge)
        add(1, 0,  0, 0, 0,   1, 0,  0, 0);
        add(0, 0,  0, 0, 0,   1, 0,  0, 0);
        // len=3: 10,20,30 back-to-back
        add(0, 1, 10, 3, 0,   1, 0, 10, 1);
        add(0, 1, 20, 3, 0,   1, 0, 30, 2);
        add(0, 1, 30, 3, 0,   0, 1, 60, 3);
        add(0, 0,  0, 3, 1,   1, 0,  0, 0);
        // len=2: 7,9 then held for 5 cycles while 99 is offered
        add(0, 1,  7, 2, 0,   1, 0,  7, 1);
        add(0, 1,  9, 2, 0,   0, 1, 16, 2);
        for (int i = 0; i < 5; i++) add(0, 1, 99, 2, 0, 0, 1, 16, 2);
        add(0, 1, 99, 1, 1,   1, 0,  0, 0);
        // the product held upstream during DONE is taken next
        add(0, 1, 99, 1, 0,   0, 1, 99, 1);
        add(0, 0,  0, 1, 1,   1, 0,  0, 0);
        // len=0 means 16 products of 225
        for (int i = 1; i <= 16; i++)
            add(0, 1, 225, 0, 0, (i != 16), (i == 16), 225 * i, i);
        add(0, 0,  0, 0, 1,   1, 0,  0, 0);
        // len=4 with gaps, len changed to 1 mid-frame
        add(0, 1,  1, 4, 0,   1, 0,  1, 1);
        add(0, 1,  2, 1, 0,   1, 0,  3, 2);
        add(0, 0,  0, 1, 0,   1, 0,  3, 2);
        add(0, 1,  3, 1, 0,   1, 0,  6, 3);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 1, 0, 6, 3);
        add(0, 1,  4, 1, 0,   0, 1, 10, 4);
        add(0, 0,  0, 1, 1,   1, 0,  0, 0);
        // reset after 2 of 5 products, then a len=1 frame of 5
        add(0, 1,  1, 5, 0,   1, 0,  1, 1);
        add(0, 1,  2, 5, 0,   1, 0,  3, 2);
        add(1, 1,  3, 5, 0,   1, 0,  0, 0);
        add(0, 1,  5, 1, 0,   0, 1,  5, 1);
        add(0, 0,  0, 1, 1,   1, 0,  0, 0);
        // len=1 with continuous p_valid and out_ready
        add(0, 1,  5, 1, 1,   0, 1,  5, 1);
        add(0, 1,  6, 1, 1,   1, 0,  0, 0);
        add(0, 1,  6, 1, 1,   0, 1,  6, 1);
        add(0, 1,  7, 1, 1,   1, 0,  0, 0);
        add(0, 1,  7, 1, 1,   0, 1,  7, 1);
        add(0, 0,  0, 1, 1,   1, 0,  0, 0);
        // unconsumed result dropped by reset
        add(0, 1,  8, 1, 0,   0, 1,  8, 1);
        add(1, 0,  0, 1, 0,   1, 0,  0, 0);
        add(0, 0,  0, 1, 0,   1, 0,  0, 0);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst       = vecs[k].rst;
            p_valid   = vecs[k].pv;
            p_in      = vecs[k].pin;
            len       = vecs[k].len;
            out_ready = vecs[k].ordy;
            @(posedge clk);
            #1;
            vectors++;
            if (p_ready !== vecs[k].e_rdy) begin
                miscompares++;
                $display("FAIL vec %0d p_ready: got %b expected %b", k, p_ready, vecs[k].e_rdy);
            end
            if (out_valid !== vecs[k].e_vld) begin
                miscompares++;
                $display("FAIL vec %0d out_valid: got %b expected %b", k, out_valid, vecs[k].e_vld);
            end
            if (out_sum !== vecs[k].e_sum) begin
                miscompares++;
                $display("FAIL vec %0d out_sum: got %0d expected %0d", k, out_sum, vecs[k].e_sum);
            end
            if (out_count !== vecs[k].e_cnt) begin
                miscompares++;
                $display("FAIL vec %0d out_count: got %0d expected %0d", k, out_count, vecs[k].e_cnt);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter PW, default 8, product input width in bits.
REQ-002 Parameter LW, default 4, frame-length field width in bits; maximum frame is 2**LW products.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 p_in  input  PW  unsigned product from the upstream registered multiplier.
REQ-006 p_valid  input  1  p_in is valid this cycle.
REQ-007 p_ready  output  1  block accepts p_in this cycle; a transfer occurs when p_valid && p_ready.
REQ-008 len  input  LW  frame length; sampled only on the first transfer of a frame; value 0 means 2**LW.
REQ-009 out_sum  output  PW+LW  accumulated frame sum.
REQ-010 out_count  output  LW+1  number of products in the presented frame.
REQ-011 out_valid  output  1  out_sum and out_count are valid.
REQ-012 out_ready  input  1  downstream accepts the result; a result transfer occurs when out_valid && out_ready.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-014 In IDLE and ACC, p_ready SHALL be 1; in DONE, p_ready SHALL be 0.
REQ-015 out_valid SHALL be 1 only in DONE; out_sum and out_count SHALL be registered and SHALL not depend combinationally on any input.
REQ-016 IDLE, on a transfer: acc<=p_in, cnt<=1, target<=(len==0 ? 2**LW : len); next state is DONE if the target is 1, else ACC.
REQ-017 ACC, on a transfer: acc<=acc+p_in, cnt<=cnt+1; next state is DONE when cnt+1==target, else remain in ACC.
REQ-018 ACC without a transfer (p_valid=0): all state SHALL hold; gaps of any length SHALL be allowed.
REQ-019 DONE: out_sum=acc and out_count=cnt SHALL be held stable while out_ready=0.
REQ-020 DONE with out_ready=1: next state is IDLE; acc and cnt SHALL be cleared the same edge.
REQ-021 Latency: out_valid SHALL rise on the clock edge that captures the last product of the frame, i.e. it is visible in the cycle after that transfer.
REQ-022 A change on len mid-frame SHALL be ignored.
REQ-023 The sum width PW+LW SHALL hold the worst case (2**LW)*(2**PW-1) without overflow; no saturation logic SHALL exist.
REQ-024 Products offered during DONE SHALL not be accepted and SHALL not be lost; upstream holds them because p_ready=0.
REQ-025 The minimum frame period SHALL be target+1 cycles: the last transfer, then DONE for at least one cycle.

Reset
REQ-026 With rst=1, the following SHALL hold on the next posedge: state=IDLE, acc=0, cnt=0, target=0, out_valid=0, out_sum=0, out_count=0.
REQ-027 rst SHALL take priority over every transfer; a partial frame SHALL be discarded, and an unconsumed DONE result SHALL be dropped.
REQ-028 In the cycle rst is asserted, p_ready SHALL still follow the current state; no transfer SHALL take effect.

Structure
REQ-029 Package accum_pkg SHALL hold the state enum (IDLE/ACC/DONE) and the default PW/LW constants.
REQ-030 The block SHALL be a single module with no sub-module; counter and adder SHALL be inline.
REQ-031 A bound property module SHALL check: out_valid stable until out_ready; out_sum/out_count stable while out_valid && !out_ready; never p_ready && out_valid.

Verification
REQ-032 Scenario: len=3, products 10,20,30 back-to-back -> out_valid=1 the cycle after the third, out_sum=60, out_count=3.
REQ-033 Scenario: len=0, 16 products of 225 -> out_sum=3600, out_count=16, no overflow.
REQ-034 Scenario: len=2, products 7,9 with out_ready=0 for 5 cycles -> out_sum=16 held stable, p_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-035 Scenario: len=4, p_valid gaps of 0-3 cycles, products 1,2,3,4, len changed to 1 after the first product -> out_sum=10, out_count=4.
REQ-036 Scenario: rst pulsed after 2 of 5 products -> all outputs 0; the next frame, len=1 product 5, yields out_sum=5, out_count=1.
REQ-037 Scenario: len=1 with continuous p_valid -> each frame out_sum=p_in and out_count=1, with one DONE cycle per product.
